// File: rtl/obi_resp_pkg.sv
// Shared types for the OBI memory responder: response queue entry and the
// fill pattern returned for out-of-range reads.
package obi_resp_pkg;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  cnt;
    } resp_entry_t;

    localparam logic [31:0] OOB_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/obi_resp_fifo.sv
// In-order response queue; each entry carries a countdown that drops by one per
// cycle (saturating) so the head knows when its latency has elapsed.
module obi_resp_fifo
    import obi_resp_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  resp_entry_t                entry_i,
    input  logic                       pop_i,
    output resp_entry_t                head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

    resp_entry_t     entries_q [Depth];
    resp_entry_t     entries_d [Depth];
    logic [CntW-1:0] count_q, count_d, base;
    logic            do_pop, do_push;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign head_o  = entries_q[0];

    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot a simultaneous push needs, so full does not block it.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        for (int unsigned i = 0; i < Depth; i++) begin
            entries_d[i] = entries_q[i];
            if (entries_q[i].cnt != 3'd0) begin
                entries_d[i].cnt = entries_q[i].cnt - 3'd1;
            end
        end
        if (do_pop) begin
            for (int unsigned i = 0; i + 1 < Depth; i++) begin
                entries_d[i] = entries_d[i + 1];
            end
            entries_d[Depth - 1] = '0;
        end
        base = count_q - CntW'(do_pop);
        if (do_push) begin
            entries_d[base[IdxW-1:0]] = entry_i;
        end
        count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entries_q <= '{default: '0};
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/obi_mem_responder.sv
// Memory-side req/gnt/rvalid responder: word array with byte-enabled writes,
// in-order responses after a programmable latency, and grant/response stalls.
module obi_mem_responder
    import obi_resp_pkg::*;
#(
    parameter int unsigned MEM_WORDS       = 256,
    parameter int unsigned RESP_LATENCY    = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    input  logic        gnt_stall_i,
    input  logic        rvalid_stall_i,
    output logic        oob_o
);

    localparam int unsigned AddrW = $clog2(MEM_WORDS);
    localparam int unsigned CntW  = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]      mem [MEM_WORDS];
    logic [AddrW-1:0] word_idx;
    logic             in_range, retire_now, grant, fifo_empty, unused_full;
    logic [CntW-1:0]  outstanding;
    logic [1:0]       unused_addr;
    resp_entry_t      push_entry, head;

    logic        rvalid_q, rvalid_d, oob_q, oob_d;
    logic [31:0] rdata_q, rdata_d;

    assign unused_addr = addr_i[1:0];
    assign word_idx    = addr_i[AddrW+1:2];
    assign in_range    = (addr_i[31:AddrW+2] == '0);

    // Retiring head frees a slot this edge, which keeps full-rate streaming alive.
    assign retire_now = !fifo_empty && (head.cnt == 3'd0) && !rvalid_stall_i;
    assign grant      = req_i && !gnt_stall_i &&
                        ((32'(outstanding) < MAX_OUTSTANDING) || retire_now);
    assign gnt_o      = grant;

    always_comb begin
        push_entry.cnt = 3'(RESP_LATENCY - 1);
        if (we_i) begin
            push_entry.data = '0;
        end else if (in_range) begin
            push_entry.data = mem[word_idx];
        end else begin
            push_entry.data = OOB_RDATA;
        end
    end

    always_ff @(posedge clk_i) begin
        if (grant && we_i && in_range) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    obi_resp_fifo #(
        .Depth (MAX_OUTSTANDING)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant),
        .entry_i (push_entry),
        .pop_i   (retire_now),
        .head_o  (head),
        .full_o  (unused_full),
        .empty_o (fifo_empty),
        .count_o (outstanding)
    );

    always_comb begin
        rvalid_d = retire_now;
        rdata_d  = retire_now ? head.data : '0;
        oob_d    = grant && !in_range;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            oob_q    <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            oob_q    <= oob_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign oob_o    = oob_q;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Self-checking bench for obi_mem_responder: vector table plus hand-written
// back-pressure, stall and reset sequences, checked through a response scoreboard.
module tb_obi_mem_responder;

    localparam int unsigned MemWords = 256;
    localparam int unsigned RespLat  = 3;
    localparam int unsigned MaxOut   = 2;

    logic        clk, rst_n, req, gnt, we, rvalid, gnt_stall, rvalid_stall, oob;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;

    obi_mem_responder #(
        .MEM_WORDS       (MemWords),
        .RESP_LATENCY    (RespLat),
        .MAX_OUTSTANDING (MaxOut)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_i          (req),
        .gnt_o          (gnt),
        .addr_i         (addr),
        .we_i           (we),
        .be_i           (be),
        .wdata_i        (wdata),
        .rvalid_o       (rvalid),
        .rdata_o        (rdata),
        .gnt_stall_i    (gnt_stall),
        .rvalid_stall_i (rvalid_stall),
        .oob_o          (oob)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_oob;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        oob;
        int          g;
        int          lat;
    } exp_t;

    int          checks;
    int          failures;
    int          cyc;
    bit          mon_en;
    exp_t        exp_q[$];
    logic [31:0] obs_data [64];
    int          obs_cyc [64];
    int          obs_n;
    int          rd_idx;
    bit          oob_seen [4096];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Record every response and oob pulse with the cycle it was seen in.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (rvalid && obs_n < 64) begin
                obs_data[obs_n] <= rdata;
                obs_cyc[obs_n]  <= cyc;
                obs_n           <= obs_n + 1;
            end
            if (oob && cyc < 4096) oob_seen[cyc] <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; leaves req high so the next call follows back-to-back.
    task automatic issue(input vec_t v, input int lat);
        bit got;
        got   = 1'b0;
        req   = 1'b1;
        we    = v.we;
        addr  = v.addr;
        be    = v.be;
        wdata = v.wdata;
        for (int w = 0; w < 40 && !got; w++) begin
            @(negedge clk);
            got = gnt;
        end
        check("grant_wait", {31'b0, got}, 32'd1);
        if (got) exp_q.push_back('{data: v.exp_data, oob: v.exp_oob, g: cyc + 1, lat: lat});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        exp_t e;
        for (int w = 0; w < 100 && obs_n < rd_idx + int'(exp_q.size()); w++) @(negedge clk);
        repeat (3) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("oob_pulse", {31'b0, oob_seen[e.g]}, {31'b0, e.oob});
            if (rd_idx < obs_n) begin
                check("rdata", obs_data[rd_idx], e.data);
                check("latency", obs_cyc[rd_idx] - e.g, e.lat);
                rd_idx++;
            end else begin
                check("resp_missing", obs_n, rd_idx + 1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        vecs [13];
        vec_t        v;
        logic [31:0] bp_addr [4];
        logic [31:0] bp_data [4];
        bit          bp_pat [6];
        bit          got;
        int          k;

        vecs[0]  = '{1'b1, 32'h0000_0040, 4'hF, 32'h1122_3344, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0040, 4'h0, 32'h0,         32'h1122_3344, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0040, 4'h5, 32'hAABB_CCDD, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0040, 4'h0, 32'h0,         32'h11BB_33DD, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_1000, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b1};
        vecs[5]  = '{1'b1, 32'h0000_1040, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b0, 32'h0000_0040, 4'h0, 32'h0,         32'h11BB_33DD, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0044, 4'hF, 32'h5566_7788, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0044, 4'h8, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0044, 4'h0, 32'h0,         32'h0066_7788, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_03FC, 4'hF, 32'h0BAD_CAFE, 32'h0000_0000, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_03FC, 4'h0, 32'h0,         32'h0BAD_CAFE, 1'b0};
        vecs[12] = '{1'b0, 32'h0000_0400, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b1};

        bp_addr = '{32'h40, 32'h44, 32'h3FC, 32'h40};
        bp_data = '{32'h11BB_33DD, 32'h0066_7788, 32'h0BAD_CAFE, 32'h11BB_33DD};
        bp_pat  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
        gnt_stall = 1'b0; rvalid_stall = 1'b0; mon_en = 1'b1;

        repeat (3) @(negedge clk);
        check("reset_rvalid", {31'b0, rvalid}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_oob", {31'b0, oob}, 32'd0);
        check("reset_gnt", {31'b0, gnt}, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("idle_gnt", {31'b0, gnt}, 32'd0);
        @(posedge clk);
        #1;

        // Table vectors, issued back-to-back (covers read one cycle after write).
        for (int i = 0; i < 13; i++) issue(vecs[i], RespLat);
        req = 1'b0;
        drain();
        check("idle_rdata", rdata, 32'd0);

        // Back-pressure: req held high, address advanced after each grant.
        k    = 0;
        req  = 1'b1; we = 1'b0; be = 4'h0;
        addr = bp_addr[0];
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_gnt", {31'b0, gnt}, {31'b0, bp_pat[i]});
            if (gnt && k < 4) begin
                exp_q.push_back('{data: bp_data[k], oob: 1'b0, g: cyc + 1, lat: RespLat});
                k++;
                @(posedge clk);
                #1 addr = bp_addr[k % 4];
            end
        end
        @(posedge clk);
        #1 req = 1'b0;
        drain();

        // Grant stall for two cycles.
        gnt_stall = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h44;
        @(negedge clk);
        check("gstall_0", {31'b0, gnt}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("gstall_1", {31'b0, gnt}, 32'd0);
        @(posedge clk);
        #1 gnt_stall = 1'b0;
        @(negedge clk);
        check("gstall_release", {31'b0, gnt}, 32'd1);
        if (gnt) exp_q.push_back('{data: 32'h0066_7788, oob: 1'b0, g: cyc + 1, lat: RespLat});
        @(posedge clk);
        #1 req = 1'b0;
        drain();

        // Response stall held for three cycles once the head is due.
        v = '{1'b0, 32'h0000_03FC, 4'h0, 32'h0, 32'h0BAD_CAFE, 1'b0};
        issue(v, RespLat + 3);
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rvalid_stall = 1'b1;
        repeat (3) @(posedge clk);
        #1 rvalid_stall = 1'b0;
        drain();

        // Reset while the queue is full and a response is on the bus.
        mon_en = 1'b0;
        req = 1'b1; we = 1'b0; addr = 32'h40;
        got = 1'b0;
        for (int w = 0; w < 20 && !got; w++) begin
            @(negedge clk);
            got = rvalid;
        end
        check("rst_setup_rvalid", {31'b0, got}, 32'd1);
        #2 rst_n = 1'b0;
        req = 1'b0;
        #1;
        check("rst_async_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_async_rdata", rdata, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1 req = 1'b1; we = 1'b0; addr = 32'h44;
        @(negedge clk);
        check("post_rst_gnt", {31'b0, gnt}, 32'd1);
        if (gnt) exp_q.push_back('{data: 32'h0066_7788, oob: 1'b0, g: cyc + 1, lat: RespLat});
        @(posedge clk);
        #1 req = 1'b0;
        drain();

        repeat (5) @(negedge clk);
        check("extra_resp", obs_n, rd_idx);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
